// File: rtl/ycbcr_pkg.sv
// Shared constants and helpers for the RGB->YCbCr flow controller.
package ycbcr_pkg;

    // Tag bit positions in the {v,sof,eol} delay-line word
    localparam int unsigned TAG_V   = 0;
    localparam int unsigned TAG_SOF = 1;
    localparam int unsigned TAG_EOL = 2;
    localparam int unsigned TAG_W   = 3;

    // Default datapath geometry
    localparam int unsigned DEF_LAT   = 3;
    localparam int unsigned DEF_DSIZE = 24;
    localparam int unsigned DEF_DEPTH = 8;

    // Ceiling log2, usable in parameter expressions
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO with synchronous reset, flush clear and overflow flag.
module sync_fifo_fwft #(
    parameter int unsigned W     = 26,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic [AW:0]   count,
    output logic          ovf
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    logic          r_ovf;

    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_wr_en;

    // Pop only when something is held; a full FIFO still accepts a push alongside a pop
    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_pop   = pop & (r_count != '0);
    assign w_push  = push & (~w_full | w_pop);
    assign w_wr_en = w_push & ~rst & ~flush;

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr] <= wdata;
    end

    // Pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            if (push & ~w_push) r_ovf <= 1'b1;
        end
    end

    assign rdata = r_mem[r_rd];
    assign count = r_count;
    assign ovf   = r_ovf;

endmodule

// File: rtl/ycbcr_flow_ctrl.sv
// Credit-based flow control around a fixed-latency, non-stallable colour converter.
module ycbcr_flow_ctrl
    import ycbcr_pkg::*;
#(
    parameter int unsigned LAT   = DEF_LAT,
    parameter int unsigned DSIZE = DEF_DSIZE,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             s_valid,
    input  logic             s_sof,
    input  logic             s_eol,
    output logic             s_ready,
    output logic             dp_in_valid,
    input  logic [DSIZE-1:0] dp_d,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DSIZE-1:0] m_data,
    output logic             m_sof,
    output logic             m_eol,
    output logic [AW:0]      level,
    output logic             ovf_err
);

    localparam int unsigned FW = DSIZE + 2;

    logic [AW:0]      r_level;
    logic [TAG_W-1:0] r_tag [LAT];

    logic             w_accept;
    logic             w_pop;
    logic [TAG_W-1:0] w_tag_in;
    logic [FW-1:0]    w_wdata;
    logic [FW-1:0]    w_rdata;
    logic [AW:0]      w_count;
    logic             w_ovf;

    // A credit is free whenever fewer than DEPTH pixels are in flight or buffered
    assign s_ready     = (r_level < (AW+1)'(DEPTH)) & ~flush & ~rst;
    assign w_accept    = s_valid & s_ready;
    assign dp_in_valid = w_accept;
    assign w_pop       = m_valid & m_ready;

    // Tag word entering the delay line this cycle
    always_comb begin
        w_tag_in          = '0;
        w_tag_in[TAG_V]   = w_accept;
        w_tag_in[TAG_SOF] = s_sof;
        w_tag_in[TAG_EOL] = s_eol;
    end

    // Credit counter: one per accepted pixel, returned on pop
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_level <= '0;
        end else begin
            r_level <= r_level + (AW+1)'(w_accept) - (AW+1)'(w_pop);
        end
    end

    // Tag delay line matching the converter's register depth; never stalls
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < LAT; i++) r_tag[i] <= '0;
        end else begin
            r_tag[0] <= w_tag_in;
            for (int i = 1; i < LAT; i++) r_tag[i] <= r_tag[i-1];
        end
    end

    assign w_wdata = {dp_d, r_tag[LAT-1][TAG_SOF], r_tag[LAT-1][TAG_EOL]};

    sync_fifo_fwft #(
        .W     (FW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (r_tag[LAT-1][TAG_V]),
        .wdata (w_wdata),
        .pop   (w_pop),
        .rdata (w_rdata),
        .count (w_count),
        .ovf   (w_ovf)
    );

    // Markers are masked so a stale head entry never shows a marker
    assign m_valid = (w_count != '0);
    assign m_data  = w_rdata[FW-1:2];
    assign m_sof   = w_rdata[1] & m_valid;
    assign m_eol   = w_rdata[0] & m_valid;
    assign level   = r_level;
    assign ovf_err = w_ovf;

endmodule

// File: tb/tb_ycbcr_flow_ctrl.sv
// Directed bench for ycbcr_flow_ctrl; converter modelled as a LAT-stage delay.
module tb_ycbcr_flow_ctrl;

    localparam int LAT   = 3;
    localparam int DSIZE = 24;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             s_valid;
    logic             s_sof;
    logic             s_eol;
    logic             s_ready;
    logic             dp_in_valid;
    logic [DSIZE-1:0] pix;
    logic [DSIZE-1:0] dp_d;
    logic             m_valid;
    logic             m_ready;
    logic [DSIZE-1:0] m_data;
    logic             m_sof;
    logic             m_eol;
    logic [AW:0]      level;
    logic             ovf_err;

    int n_vec = 0;
    int n_err = 0;

    logic [DSIZE-1:0] r_dp [LAT];

    always #5 clk = ~clk;

    // Converter model: pure LAT-cycle delay of the pixel bus
    always @(posedge clk) begin
        r_dp[0] <= pix;
        for (int i = 1; i < LAT; i++) r_dp[i] <= r_dp[i-1];
    end
    assign dp_d = r_dp[LAT-1];

    ycbcr_flow_ctrl #(
        .LAT   (LAT),
        .DSIZE (DSIZE),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .s_valid     (s_valid),
        .s_sof       (s_sof),
        .s_eol       (s_eol),
        .s_ready     (s_ready),
        .dp_in_valid (dp_in_valid),
        .dp_d        (dp_d),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_sof       (m_sof),
        .m_eol       (m_eol),
        .level       (level),
        .ovf_err     (ovf_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; s_valid = 1'b1; s_sof = 1'b0; s_eol = 1'b0;
        m_ready = 1'b0; pix = '0;
        tick(); tick();
        @(negedge clk);
        n_vec++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL reset_s_ready got=%b exp=0", s_ready); end
        n_vec++; if (dp_in_valid !== 1'b0) begin n_err++; $display("FAIL reset_dp_in_valid got=%b exp=0", dp_in_valid); end
        n_vec++; if (level !== 4'd0) begin n_err++; $display("FAIL reset_level got=%0d exp=0", level); end
        n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
        n_vec++; if (m_sof !== 1'b0 || m_eol !== 1'b0) begin n_err++; $display("FAIL reset_markers got=%b%b exp=00", m_sof, m_eol); end
        n_vec++; if (ovf_err !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b exp=0", ovf_err); end
        tick();
        rst = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_s_ready got=%b exp=1", s_ready); end
        tick();
    endtask

    task automatic test_single();
        for (int c = 0; c < 7; c++) begin
            s_valid = (c == 0);
            pix     = (c == 0) ? 24'h123456 : 24'h0;
            m_ready = 1'b1;
            @(negedge clk);
            if (c == 0) begin
                n_vec++; if (dp_in_valid !== 1'b1) begin n_err++; $display("FAIL single_accept got=%b exp=1", dp_in_valid); end
            end
            n_vec++; if (m_valid !== (c == 4)) begin n_err++; $display("FAIL single_m_valid c=%0d got=%b exp=%b", c, m_valid, (c == 4)); end
            if (c == 4) begin
                n_vec++; if (m_data !== 24'h123456) begin n_err++; $display("FAIL single_data got=%h exp=123456", m_data); end
            end
            if (c >= 1 && c <= 4) begin
                n_vec++; if (level !== 4'd1) begin n_err++; $display("FAIL single_level c=%0d got=%0d exp=1", c, level); end
            end
            if (c == 5) begin
                n_vec++; if (level !== 4'd0) begin n_err++; $display("FAIL single_level_ret got=%0d exp=0", level); end
            end
            tick();
        end
    endtask

    task automatic test_fill();
        int acc = 0;
        for (int c = 0; c < 12; c++) begin
            s_valid = 1'b1;
            pix     = 24'hA00000 + 24'(acc);
            m_ready = 1'b0;
            @(negedge clk);
            n_vec++; if (s_ready !== (c < 8)) begin n_err++; $display("FAIL fill_s_ready c=%0d got=%b exp=%b", c, s_ready, (c < 8)); end
            if (s_valid && s_ready) acc++;
            if (c == 11) begin
                n_vec++; if (acc != 8) begin n_err++; $display("FAIL fill_accepts got=%0d exp=8", acc); end
                n_vec++; if (level !== 4'd8) begin n_err++; $display("FAIL fill_level got=%0d exp=8", level); end
                n_vec++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL fill_m_valid got=%b exp=1", m_valid); end
                n_vec++; if (ovf_err !== 1'b0) begin n_err++; $display("FAIL fill_ovf got=%b exp=0", ovf_err); end
            end
            tick();
        end
    endtask

    task automatic test_pop_accept();
        int  pops = 0;
        bit  done = 0;
        logic [DSIZE-1:0] exp_d;
        s_valid = 1'b0; m_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (m_data !== 24'hA00000) begin n_err++; $display("FAIL pa_first_data got=%h exp=a00000", m_data); end
        n_vec++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL pa_full_ready got=%b exp=0", s_ready); end
        tick();
        s_valid = 1'b1; pix = 24'hB00000; m_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (level !== 4'd7) begin n_err++; $display("FAIL pa_level_after_pop got=%0d exp=7", level); end
        n_vec++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL pa_ready_after_pop got=%b exp=1", s_ready); end
        n_vec++; if (m_data !== 24'hA00001) begin n_err++; $display("FAIL pa_second_data got=%h exp=a00001", m_data); end
        tick();
        s_valid = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (c == 0) begin
                n_vec++; if (level !== 4'd7) begin n_err++; $display("FAIL pa_level_hold got=%0d exp=7", level); end
            end
            if (m_valid) begin
                exp_d = (pops < 6) ? 24'hA00002 + 24'(pops) : 24'hB00000;
                n_vec++; if (m_data !== exp_d) begin n_err++; $display("FAIL pa_drain_data k=%0d got=%h exp=%h", pops, m_data, exp_d); end
                pops++;
            end
            if (level == 4'd0) done = 1;
            tick();
            if (done) break;
        end
        n_vec++; if (!done || pops != 7) begin n_err++; $display("FAIL pa_drain_done pops=%0d exp=7 done=%0d", pops, done); end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 108; c++) begin
            s_valid = (c < 100);
            pix     = 24'(c);
            m_ready = 1'b1;
            @(negedge clk);
            if (c < 100) begin
                n_vec++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready c=%0d got=%b exp=1", c, s_ready); end
            end
            n_vec++; if (m_valid !== (c >= 4 && c <= 103)) begin n_err++; $display("FAIL b2b_m_valid c=%0d got=%b", c, m_valid); end
            if (c >= 4 && c <= 103) begin
                n_vec++; if (m_data !== 24'(c - 4)) begin n_err++; $display("FAIL b2b_data c=%0d got=%h exp=%h", c, m_data, 24'(c - 4)); end
            end
            tick();
        end
    endtask

    task automatic test_flush();
        for (int c = 0; c < 16; c++) begin
            s_valid = (c < 5);
            pix     = 24'hC00000 + 24'(c);
            m_ready = (c >= 6);
            flush   = (c == 5);
            @(negedge clk);
            if (c == 5) begin
                n_vec++; if (level !== 4'd5) begin n_err++; $display("FAIL flush_pre_level got=%0d exp=5", level); end
                n_vec++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL flush_pre_m_valid got=%b exp=1", m_valid); end
                n_vec++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready got=%b exp=0", s_ready); end
            end
            if (c == 6) begin
                n_vec++; if (level !== 4'd0) begin n_err++; $display("FAIL flush_level got=%0d exp=0", level); end
                n_vec++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL flush_post_ready got=%b exp=1", s_ready); end
            end
            if (c >= 6) begin
                n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL flush_m_valid c=%0d got=%b exp=0", c, m_valid); end
            end
            tick();
        end
        flush = 1'b0;
    endtask

    task automatic test_line();
        int idx = 0;
        int ob  = 0;
        for (int c = 0; c < 4000; c++) begin
            s_valid = (idx < 640);
            pix     = 24'(idx) ^ 24'h5A5A5A;
            s_sof   = (idx == 0);
            s_eol   = (idx == 639);
            m_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (m_valid && m_ready) begin
                n_vec++; if (m_data !== (24'(ob) ^ 24'h5A5A5A)) begin n_err++; $display("FAIL line_data beat=%0d got=%h exp=%h", ob, m_data, 24'(ob) ^ 24'h5A5A5A); end
                n_vec++; if (m_sof !== (ob == 0)) begin n_err++; $display("FAIL line_sof beat=%0d got=%b exp=%b", ob, m_sof, (ob == 0)); end
                n_vec++; if (m_eol !== (ob == 639)) begin n_err++; $display("FAIL line_eol beat=%0d got=%b exp=%b", ob, m_eol, (ob == 639)); end
                ob++;
            end
            if (s_valid && s_ready) idx++;
            tick();
            if (ob == 640) break;
        end
        s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0; m_ready = 1'b1;
        n_vec++; if (ob != 640 || idx != 640) begin n_err++; $display("FAIL line_count beats=%0d accepts=%0d exp=640", ob, idx); end
        @(negedge clk);
        n_vec++; if (level !== 4'd0 || m_valid !== 1'b0) begin n_err++; $display("FAIL line_drained level=%0d m_valid=%b exp=0/0", level, m_valid); end
        n_vec++; if (ovf_err !== 1'b0) begin n_err++; $display("FAIL line_ovf got=%b exp=0", ovf_err); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_pop_accept();
        test_back_to_back();
        test_flush();
        test_line();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
